// File: rtl/bundle_fetch_unit.sv
// Bundle fetch unit: single-outstanding fetch FSM feeding a DEPTH-entry prefetch
// FIFO, with one-cycle issue pulses gated by the functional-unit busy flags.

module bundle_fetch_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst)       q <= '0;
    else if (load) q <= d;
endmodule

module bundle_fetch_unit #(
  parameter  int          NFU             = 2,
  parameter  int          DEPTH           = 4,
  parameter  logic [63:0] RESETPC         = 64'h0,
  localparam int          INSTRUCTIONSIZE = NFU * 32,
  localparam int          CW              = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [63:0]                fetchAddress,
  output logic                       doFetch,
  input  logic                       doneFetch,
  input  logic [INSTRUCTIONSIZE-1:0] fetchData,
  input  logic                       redirect,
  input  logic [63:0]                redirectAddress,
  input  logic [NFU-1:0]             fuWorking,
  output logic [INSTRUCTIONSIZE-1:0] instruction,
  output logic [63:0]                bundleAddr,
  output logic                       instructionReady,
  output logic [CW-1:0]              bufferCount
);

  localparam int          PW     = $clog2(DEPTH);
  localparam logic [63:0] STRIDE = 64'(NFU * 4);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQUEST, DISCARD} state_t;

  typedef struct packed {
    logic [INSTRUCTIONSIZE-1:0] data;
    logic [63:0]                addr;
  } entry_t;

  state_t        state, state_nxt;
  logic [63:0]   next_pc, next_pc_nxt;
  logic          launch, push, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  entry_t        mem [DEPTH];
  entry_t        head;

  assign doFetch = (state != IDLE);
  assign head    = mem[rd_ptr];
  // Redirect outranks issue so a flushed head can never leak out.
  assign pop     = (bufferCount != '0) && (fuWorking == '0) && !instructionReady && !redirect;

  always_comb begin
    state_nxt   = state;
    next_pc_nxt = next_pc;
    launch      = 1'b0;
    push        = 1'b0;
    case (state)
      IDLE:
        if (!redirect && bufferCount < FULL) begin
          state_nxt = REQUEST;
          launch    = 1'b1;
        end
      REQUEST:
        if (doneFetch) begin
          state_nxt = IDLE;
          if (!redirect) begin
            push        = 1'b1;
            next_pc_nxt = next_pc + STRIDE;
          end
        end else if (redirect) begin
          state_nxt = DISCARD;
        end
      // The stale response still has to drain before a new request goes out.
      DISCARD:
        if (doneFetch) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect) next_pc_nxt = redirectAddress;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      next_pc      <= RESETPC;
      fetchAddress <= RESETPC;
    end else begin
      state   <= state_nxt;
      next_pc <= next_pc_nxt;
      if (launch) fetchAddress <= next_pc;
    end

  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= '{data: fetchData, addr: fetchAddress};

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bufferCount <= '0;
    end else if (redirect) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      bufferCount <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      bufferCount <= bufferCount + CW'(push) - CW'(pop);
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      instructionReady <= 1'b0;
      bundleAddr       <= '0;
    end else begin
      instructionReady <= pop;
      if (pop) bundleAddr <= head.addr;
    end

  for (genvar k = 0; k < NFU; k++) begin : g_slot
    bundle_fetch_slot u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (pop),
      .d    (head.data[32*k +: 32]),
      .q    (instruction[32*k +: 32])
    );
  end

endmodule
